hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 10 +
 rtl/sb_entry.sv | 26 ++
 rtl/hazard_scoreboard.sv | 82 ++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the decode-stage hazard scoreboard.
package hazard_pkg;
  localparam int NREG     = 16;
  localparam int MAX_LAT  = 3;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int RIDX_W   = $clog2(NREG);

  typedef logic [RIDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: cycles remaining until a register's pending result is written.
module sb_entry #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] lat_i,
  output logic [CW-1:0] cnt_o
);
  logic [CW-1:0] cnt_q, cnt_d, dec;

  always_comb begin
    dec   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    cnt_d = dec;
    // A younger, shorter write must not make an older, slower one look done (WAW).
    if (load_i) cnt_d = (lat_i > dec) ? lat_i : dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW interlock: per-register latency counters, forwarding slack,
// stall-run length and a sticky watchdog for runaway stalls.
module hazard_scoreboard #(
  parameter int NREG      = hazard_pkg::NREG,
  parameter int MAX_LAT   = hazard_pkg::MAX_LAT,
  parameter int FWD_SLACK = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fd_valid,
  input  logic                       flush,
  input  logic [$clog2(NREG)-1:0]    fd_rs,
  input  logic [$clog2(NREG)-1:0]    fd_rt,
  input  logic [$clog2(NREG)-1:0]    fd_rd,
  input  logic                       fd_rs_used,
  input  logic                       fd_rt_used,
  input  logic                       fd_regwrite,
  input  logic                       fd_is_branch,
  input  logic [$clog2(MAX_LAT+1)-1:0] fd_lat,
  output logic                       stall_sig,
  output logic                       fd_fire,
  output logic [15:0]                stall_cnt,
  output logic                       err
);
  import hazard_pkg::*;

  localparam int IW = $clog2(NREG);
  localparam int CW = $clog2(MAX_LAT+1);
  localparam logic [15:0] WDOG_LIM = 16'(MAX_LAT);

  logic [NREG-1:0][CW-1:0] cnt;
  logic [NREG-1:0]         ld;
  logic [31:0]             slack;
  logic                    rs_haz, rt_haz;
  logic [CW-1:0]           lat_clamp;
  logic [15:0]             stall_cnt_q, stall_cnt_d;
  logic                    err_q, err_d;

  // Branches resolve in decode, so they cannot take a forwarded result.
  assign slack  = fd_is_branch ? 32'd0 : 32'(FWD_SLACK);
  assign rs_haz = fd_rs_used && (fd_rs != '0) && (32'(cnt[fd_rs]) > slack);
  assign rt_haz = fd_rt_used && (fd_rt != '0) && (32'(cnt[fd_rt]) > slack);

  assign stall_sig = fd_valid && !flush && (rs_haz || rt_haz);
  assign fd_fire   = fd_valid && !flush && !stall_sig;

  assign lat_clamp = (32'(fd_lat) > 32'(MAX_LAT)) ? CW'(MAX_LAT) : fd_lat;

  for (genvar r = 0; r < NREG; r++) begin : g_ent
    if (r == 0) begin : g_r0
      assign ld[r] = 1'b0;
    end else begin : g_rn
      assign ld[r] = fd_fire && fd_regwrite && (fd_rd == IW'(r));
    end
    sb_entry #(.CW(CW)) u_ent (
      .clk    (clk),
      .rst    (rst),
      .load_i (ld[r]),
      .lat_i  (lat_clamp),
      .cnt_o  (cnt[r])
    );
  end

  always_comb begin
    stall_cnt_d = '0;
    if (stall_sig) stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
    err_d = err_q || (stall_cnt_d > WDOG_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;
endmodule
